module_codificador_hamming: RTL
===============================

MODULE_CODIFICADOR_HAMMING -- requirements
Module: module_codificador_hamming

Interface
REQ-001 Parameter: DATA_W, default 4, data word width; legal range 4..26.
REQ-002 Parameter: SECDED, default 0; 1 appends an overall-parity bit (SEC-DED), 0 gives plain Hamming SEC.
REQ-003 Derived constant: R = smallest r with 2^r >= DATA_W + r + 1; CODE_W = DATA_W + R + SECDED.
REQ-004 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-005 Port: rst  input  1  reset; asynchronous, active-high.
REQ-006 Port: datos_in  input  DATA_W  data word to encode.
REQ-007 Port: in_valid  input  1  datos_in is valid this cycle.
REQ-008 Port: in_ready  output  1  block accepts a word this cycle.
REQ-009 Port: inj_en  input  1  sampled with an accepted word; request a single-bit error in that codeword.
REQ-010 Port: inj_pos  input  $clog2(CODE_W)  codeword bit index to invert when inj_en=1.
REQ-011 Port: datos_cod  output  CODE_W  registered codeword.
REQ-012 Port: out_valid  output  1  datos_cod holds an unconsumed codeword.
REQ-013 Port: out_ready  input  1  downstream consumes datos_cod this cycle.
REQ-014 Port: cnt_words  output  16  count of codewords consumed downstream.

Function
REQ-015 The codeword layout SHALL use positions 1..DATA_W+R; datos_cod[k-1] holds position k.
REQ-016 Parity bits SHALL sit at power-of-two positions; data bits SHALL fill the remaining positions in ascending order, datos_in[0] at the lowest.
REQ-017 Parity at position 2^j SHALL be the even parity (XOR) of all data positions whose index has bit j set.
REQ-018 With SECDED=1, datos_cod[CODE_W-1] SHALL be the XOR of all other codeword bits, computed before any injection.
REQ-019 A transfer in SHALL occur when in_valid && in_ready; a transfer out SHALL occur when out_valid && out_ready.
REQ-020 in_ready SHALL equal !out_valid || out_ready (combinational), giving full throughput with one output register.
REQ-021 Latency: a word accepted in cycle N SHALL appear on datos_cod with out_valid=1 in cycle N+1.
REQ-022 While out_valid=1 and out_ready=0, datos_cod and out_valid SHALL hold stable regardless of in_valid or datos_in.
REQ-023 Simultaneous in and out transfers SHALL load the new codeword; out_valid stays 1.
REQ-024 An out transfer with no in transfer SHALL clear out_valid; datos_cod may keep its last value.
REQ-025 If inj_en=1 at acceptance, the stored codeword SHALL have bit inj_pos inverted after full encoding, including overall parity.
REQ-026 inj_pos >= CODE_W SHALL inject nothing.
REQ-027 cnt_words SHALL increment by 1 on each out transfer and wrap from 16'hFFFF to 0.
REQ-028 Output sequencing SHALL use two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-029 EMPTY->FULL SHALL occur on an in transfer.
REQ-030 FULL->EMPTY SHALL occur on an out transfer without an in transfer.
REQ-031 All other input conditions SHALL hold the current state.

Reset
REQ-032 rst=1 SHALL immediately (asynchronously) force out_valid=0, datos_cod=0, cnt_words=0, state EMPTY; in_ready then reads 1.
REQ-033 Reset asserted while a codeword is pending SHALL discard it; no transfer is counted.
REQ-034 The first in transfer SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-035 DATA_W=4, SECDED=0, out_ready=1: send 0000, 0001, 1111 -> datos_cod 7'b0000000, 7'b0000111, 7'b1111111, each one cycle after acceptance.
REQ-036 DATA_W=4, SECDED=1: send 0001 -> 8'b10000111; send 1111 -> 8'b11111111.
REQ-037 Sweep all 16 inputs at DATA_W=4 against a reference model; repeat with 1000 random words at DATA_W=11 and 26.
REQ-038 Backpressure: out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, datos_cod stable, cnt_words unchanged; release -> one word per cycle.
REQ-039 Injection: DATA_W=4, SECDED=0, send 0001 with inj_en=1, inj_pos=2 -> 7'b0000011; inj_pos=7 -> 7'b0000111.
REQ-040 Reset mid-stream: assert rst with out_valid=1 and cnt_words=3 -> all outputs zero before the next clock edge; count restarts at 0.

Source files
------------

// File: rtl/module_codificador_hamming.sv
// Hamming SEC / SEC-DED encoder with a one-entry valid/ready output register,
// optional single-bit error injection and a count of consumed codewords.
module module_codificador_hamming #(
  parameter  int unsigned DATA_W = 4,
  parameter  int unsigned SECDED = 0,
  localparam int unsigned R      = (DATA_W <= 4)  ? 3 :
                                   (DATA_W <= 11) ? 4 :
                                   (DATA_W <= 26) ? 5 : 6,
  localparam int unsigned N_POS  = DATA_W + R,
  localparam int unsigned CODE_W = N_POS + SECDED,
  localparam int unsigned IDX_W  = $clog2(CODE_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] datos_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              inj_en,
  input  logic [IDX_W-1:0]  inj_pos,
  output logic [CODE_W-1:0] datos_cod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       cnt_words
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t             state;
  state_t             next_state;
  logic               in_xfer_c;
  logic               out_xfer_c;
  logic [N_POS-1:0]   placed_c;
  logic [N_POS-1:0]   hamming_c;
  logic [CODE_W-1:0]  code_c;
  logic [CODE_W-1:0]  inj_mask_c;

  // Number of data bits that precede codeword position pos.
  function automatic int data_idx(input int pos);
    int n;
    n = 0;
    for (int k = 1; k < pos; k++) begin
      if ((k & (k - 1)) != 0) n++;
    end
    return n;
  endfunction

  // Data positions covered by the parity bit at position 2^j.
  function automatic logic [N_POS-1:0] cover_mask(input int j);
    logic [N_POS-1:0] m;
    m = '0;
    for (int k = 1; k <= int'(N_POS); k++) begin
      if ((((k >> j) & 1) != 0) && ((k & (k - 1)) != 0)) m[k-1] = 1'b1;
    end
    return m;
  endfunction

  // Place data bits at non-power-of-two positions, parity at powers of two.
  for (genvar k = 1; k <= int'(N_POS); k++) begin : g_pos
    if ((k & (k - 1)) == 0) begin : g_par
      assign placed_c[k-1]  = 1'b0;
      assign hamming_c[k-1] = ^(placed_c & cover_mask($clog2(k)));
    end else begin : g_dat
      assign placed_c[k-1]  = datos_in[data_idx(k)];
      assign hamming_c[k-1] = placed_c[k-1];
    end
  end

  if (SECDED != 0) begin : g_secded
    assign code_c = {^hamming_c, hamming_c};
  end else begin : g_sec
    assign code_c = hamming_c;
  end

  // Out-of-range positions leave the codeword untouched.
  assign inj_mask_c = (inj_en && (32'(inj_pos) < CODE_W)) ? (CODE_W'(1) << inj_pos) : '0;

  assign out_valid  = (state == FULL);
  assign in_ready   = !out_valid || out_ready;
  assign in_xfer_c  = in_valid && in_ready;
  assign out_xfer_c = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      EMPTY:   if (in_xfer_c) next_state = FULL;
      FULL:    if (out_xfer_c && !in_xfer_c) next_state = EMPTY;
      default: next_state = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      datos_cod <= '0;
      cnt_words <= '0;
    end else begin
      if (in_xfer_c)  datos_cod <= code_c ^ inj_mask_c;
      if (out_xfer_c) cnt_words <= cnt_words + 16'd1;
    end
  end

endmodule
